// File: rtl/alu_pkg.sv
// Shared constants for the arithmetic datapath: operand width and op-select encodings.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; chained to form the ripple-carry adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_subtractor_32x32.sv
// Two's-complement ripple-carry adder/subtractor with one registered output stage and status flags.
module adder_subtractor_32x32
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic                    sel,
  output logic signed [WIDTH-1:0] S,
  output logic                    cout,
  output logic                    ovf,
  output logic                    zero,
  output logic                    neg,
  output logic                    out_valid
);

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == '0);
  endfunction

  // Signed overflow: carry into the sign bit disagrees with carry out of it.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

  logic             w_sub;
  logic [WIDTH-1:0] w_bmod;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;

  assign w_sub      = (sel == OP_SUB);
  assign w_bmod     = B ^ {WIDTH{w_sub}};
  assign w_carry[0] = w_sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (A[i]),
      .b    (w_bmod[i]),
      .cin  (w_carry[i]),
      .s    (w_sum[i]),
      .cout (w_carry[i+1])
    );
  end

  logic signed [WIDTH-1:0] r_sum_p1;
  logic                    r_cout_p1;
  logic                    r_ovf_p1;
  logic                    r_zero_p1;
  logic                    r_neg_p1;
  logic                    r_vld_p1;

  // Stage p0 -> p1: capture result and flags on a valid edge, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum_p1  <= '0;
      r_cout_p1 <= 1'b0;
      r_ovf_p1  <= 1'b0;
      r_zero_p1 <= 1'b0;
      r_neg_p1  <= 1'b0;
      r_vld_p1  <= 1'b0;
    end else begin
      r_vld_p1 <= in_valid;
      if (in_valid) begin
        r_sum_p1  <= w_sum;
        r_cout_p1 <= w_carry[WIDTH];
        r_ovf_p1  <= signed_ovf(w_carry[WIDTH-1], w_carry[WIDTH]);
        r_zero_p1 <= is_zero(w_sum);
        r_neg_p1  <= w_sum[WIDTH-1];
      end
    end
  end

  assign S         = r_sum_p1;
  assign cout      = r_cout_p1;
  assign ovf       = r_ovf_p1;
  assign zero      = r_zero_p1;
  assign neg       = r_neg_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_adder_subtractor_32x32.sv
// Self-checking bench: directed vector table, hold/reset sequences, and randomized ops vs. an arithmetic model.
module tb_adder_subtractor_32x32;
  import alu_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic signed [31:0] A = '0;
  logic signed [31:0] B = '0;
  logic               sel = 1'b0;
  logic signed [31:0] S;
  logic               cout, ovf, zero, neg, out_valid;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sel;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
    logic        v;
  } res_t;

  adder_subtractor_32x32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .sel       (sel),
    .S         (S),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer arithmetic, then reduce modulo 2^32.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    res_t   r;
    longint sa, sb, exact;
    longint ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    exact = s ? (sa - sb) : (sa + sb);
    r.s  = exact[31:0];
    r.ov = (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
    if (s) r.co = (ua >= ub);
    else   r.co = ((ua + ub) >= 64'sd4294967296);
    r.z  = (r.s == 32'd0);
    r.n  = r.s[31];
    r.v  = 1'b1;
    return r;
  endfunction

  task automatic check(input string name, input res_t e);
    logic [36:0] act, req;
    act = {$unsigned(S), cout, ovf, zero, neg, out_valid};
    req = {e.s, e.co, e.ov, e.z, e.n, e.v};
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got S=%08h cout=%b ovf=%b zero=%b neg=%b vld=%b, want S=%08h cout=%b ovf=%b zero=%b neg=%b vld=%b",
               name, S, cout, ovf, zero, neg, out_valid, e.s, e.co, e.ov, e.z, e.n, e.v);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    in_valid = v;
    A = a;
    B = b;
    sel = s;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[7];
  res_t zero_r;
  res_t held;
  res_t e;

  initial begin
    vecs[0] = '{32'h00D70B8B, 32'h00000B8B, OP_ADD, 32'h00D71716, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00D70B8B, 32'h00000B8B, OP_SUB, 32'h00D70000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h00D70B8B, 32'h80000B8B, OP_ADD, 32'h80D71716, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFFFFFF, 32'h00000001, OP_ADD, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h80000000, 32'h00000001, OP_SUB, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000001, OP_ADD, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h00000000, 32'h00000001, OP_SUB, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    zero_r = '{32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    #12;
    check("reset_state", zero_r);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, applied back-to-back.
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].sel);
      e = '{vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z, vecs[i].n, 1'b1};
      check($sformatf("vec%0d", i), e);
    end

    // Idle edge: result holds, valid drops; changing operands has no effect.
    drive(1'b0, 32'h12345678, 32'h11111111, OP_ADD);
    e.v = 1'b0;
    check("hold_idle", e);
    drive(1'b0, 32'hDEADBEEF, 32'h0, OP_SUB);
    check("hold_idle2", e);

    // Async reset mid-stream.
    drive(1'b1, 32'h00000005, 32'h00000003, OP_ADD);
    check("pre_reset", model(32'h5, 32'h3, OP_ADD));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset", zero_r);
    drive(1'b1, 32'h00000009, 32'h00000001, OP_SUB);
    check("reset_hold1", zero_r);
    drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, OP_ADD);
    check("reset_hold2", zero_r);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 32'h80000000, 32'h80000000, OP_ADD);
    check("post_reset", model(32'h80000000, 32'h80000000, OP_ADD));

    // Randomized stream with idle gaps and corner operands.
    held = model(32'h80000000, 32'h80000000, OP_ADD);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra, rb;
      logic        rs, rv;
      logic [31:0] corners[5];
      corners[0] = 32'h0;
      corners[1] = 32'h1;
      corners[2] = 32'h7FFFFFFF;
      corners[3] = 32'h80000000;
      corners[4] = 32'hFFFFFFFF;
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      rs = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 4) != 0);
      drive(rv, ra, rb, rs);
      if (rv) held = model(ra, rb, rs);
      else    held.v = 1'b0;
      check($sformatf("rand%0d", i), held);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
